// File: rtl/bp_me_dma_initiator.sv
// Block-level DMA initiator: accepts one cache-block request at a time, issues a
// DMA packet, then streams the block out (write) or gathers it in (read) one
// fill beat at a time, and returns a block response.
//
// Ports:
//   clk_i, reset_n_i                 clock, async active-low reset
//   req_*                            block request (ready-and handshake)
//   resp_*                           block response (ready-and handshake)
//   dma_pkt_o/_v_o/_yumi_i           {write_not_read, aligned addr} command
//   dma_data_o/_v_o/_yumi_i          outgoing write beats
//   dma_data_i/_v_i/_ready_and_o     incoming read beats
module bp_me_dma_initiator #(
    parameter int unsigned addr_width_p  = 28,
    parameter int unsigned fill_width_p  = 64,
    parameter int unsigned block_width_p = 512
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic                     req_v_i,
    output logic                     req_ready_and_o,
    input  logic                     req_write_i,
    input  logic [addr_width_p-1:0]  req_addr_i,
    input  logic [block_width_p-1:0] req_data_i,

    output logic                     resp_v_o,
    input  logic                     resp_ready_and_i,
    output logic                     resp_write_o,
    output logic [addr_width_p-1:0]  resp_addr_o,
    output logic [block_width_p-1:0] resp_data_o,

    output logic [addr_width_p:0]    dma_pkt_o,
    output logic                     dma_pkt_v_o,
    input  logic                     dma_pkt_yumi_i,

    output logic [fill_width_p-1:0]  dma_data_o,
    output logic                     dma_data_v_o,
    input  logic                     dma_data_yumi_i,

    input  logic [fill_width_p-1:0]  dma_data_i,
    input  logic                     dma_data_v_i,
    output logic                     dma_data_ready_and_o
);

    localparam int unsigned fills_lp        = block_width_p / fill_width_p;
    localparam int unsigned cnt_width_lp    = (fills_lp > 1) ? $clog2(fills_lp) : 1;
    localparam int unsigned offset_width_lp = $clog2(block_width_p / 8);
    localparam logic [cnt_width_lp-1:0] last_cnt_lp  = cnt_width_lp'(fills_lp - 1);
    localparam logic [addr_width_p-1:0] addr_mask_lp = {addr_width_p{1'b1}} << offset_width_lp;

    typedef enum logic [2:0] {
        e_ready,
        e_send_pkt,
        e_write_data,
        e_read_data,
        e_resp
    } state_e;

    state_e                    state_r;
    logic [cnt_width_lp-1:0]   cnt_r;
    logic                      write_r;
    logic [addr_width_p-1:0]   addr_r;
    logic [block_width_p-1:0]  data_r;
    logic                      cnt_last;

    assign cnt_last = (cnt_r == last_cnt_lp);

    // Control FSM; the counter holds at the last beat instead of wrapping.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_ready;
            cnt_r   <= '0;
        end else begin
            unique case (state_r)
                e_ready: begin
                    if (req_v_i) begin
                        state_r <= e_send_pkt;
                    end
                end
                e_send_pkt: begin
                    if (dma_pkt_yumi_i) begin
                        cnt_r   <= '0;
                        state_r <= write_r ? e_write_data : e_read_data;
                    end
                end
                e_write_data: begin
                    if (dma_data_yumi_i) begin
                        if (cnt_last) begin
                            state_r <= e_resp;
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                end
                e_read_data: begin
                    if (dma_data_v_i) begin
                        if (cnt_last) begin
                            state_r <= e_resp;
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                end
                e_resp: begin
                    if (resp_ready_and_i) begin
                        state_r <= e_ready;
                    end
                end
                default: state_r <= e_ready;
            endcase
        end
    end

    // Request capture and read-beat assembly; payload registers need no reset.
    always_ff @(posedge clk_i) begin
        if (req_ready_and_o && req_v_i) begin
            write_r <= req_write_i;
            addr_r  <= req_addr_i & addr_mask_lp;
            data_r  <= req_data_i;
        end else if ((state_r == e_read_data) && dma_data_v_i) begin
            data_r[cnt_r*fill_width_p +: fill_width_p] <= dma_data_i;
        end
    end

    // Handshakes decode straight from the state flop; ready is gated by reset.
    assign req_ready_and_o      = reset_n_i && (state_r == e_ready);
    assign dma_pkt_v_o          = (state_r == e_send_pkt);
    assign dma_pkt_o            = {write_r, addr_r};
    assign dma_data_v_o         = (state_r == e_write_data);
    assign dma_data_o           = data_r[cnt_r*fill_width_p +: fill_width_p];
    assign dma_data_ready_and_o = (state_r == e_read_data);
    assign resp_v_o             = (state_r == e_resp);
    assign resp_write_o         = write_r;
    assign resp_addr_o          = addr_r;
    assign resp_data_o          = data_r;

`ifndef SYNTHESIS
    // A consume strobe without a matching valid is a protocol slip upstream.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!dma_pkt_yumi_i || dma_pkt_v_o)
                else $warning("dma_pkt_yumi_i seen while dma_pkt_v_o low; ignored");
            assert (!dma_data_yumi_i || dma_data_v_o)
                else $warning("dma_data_yumi_i seen while dma_data_v_o low; ignored");
        end
    end
`endif

endmodule

// File: tb/tb_bp_me_dma_initiator.sv
module tb_bp_me_dma_initiator;

    localparam int unsigned AW = 28;
    localparam int unsigned FW = 64;
    localparam int unsigned BW = 512;
    localparam int          NF = 8;

    logic          clk;
    logic          reset_n_i;
    logic          req_v_i, req_ready_and_o, req_write_i;
    logic [AW-1:0] req_addr_i;
    logic [BW-1:0] req_data_i;
    logic          resp_v_o, resp_ready_and_i, resp_write_o;
    logic [AW-1:0] resp_addr_o;
    logic [BW-1:0] resp_data_o;
    logic [AW:0]   dma_pkt_o;
    logic          dma_pkt_v_o, dma_pkt_yumi_i;
    logic [FW-1:0] dma_data_o;
    logic          dma_data_v_o, dma_data_yumi_i;
    logic [FW-1:0] dma_data_i;
    logic          dma_data_v_i, dma_data_ready_and_o;

    bp_me_dma_initiator #(.addr_width_p(AW), .fill_width_p(FW), .block_width_p(BW)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i),
        .req_v_i(req_v_i), .req_ready_and_o(req_ready_and_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .resp_v_o(resp_v_o), .resp_ready_and_i(resp_ready_and_i), .resp_write_o(resp_write_o),
        .resp_addr_o(resp_addr_o), .resp_data_o(resp_data_o),
        .dma_pkt_o(dma_pkt_o), .dma_pkt_v_o(dma_pkt_v_o), .dma_pkt_yumi_i(dma_pkt_yumi_i),
        .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_yumi_i(dma_data_yumi_i),
        .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i),
        .dma_data_ready_and_o(dma_data_ready_and_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int errors  = 0;

    // Transaction-level model: backing memory plus the one open transaction.
    logic [BW-1:0] mem [logic [AW-1:0]];
    bit            txn_open = 0;
    bit            cur_write = 0;
    logic [AW-1:0] cur_addr = '0;
    logic [BW-1:0] cur_data = '0;
    int            wbeat = 0, rbeat = 0;
    bit            exp_pkt_next = 0, exp_resp_next = 0;
    bit            pkt_hold = 0, data_hold = 0, resp_hold = 0;
    int            cyc = 0, last_acc = 0;
    int            gaps[$];

    // Stimulus knobs set by the sequencer.
    int unsigned   p_req = 0, p_pkt = 100, p_data = 100, p_resp = 100, p_vin = 0;
    bit            rand_req = 0, force_write = 0, spur_yumi = 0, bp_mode = 0, tog = 0;
    int            pkt_wait = 0;
    bit            dir_pending = 0, dir_write = 0;
    logic [AW-1:0] dir_addr = '0;
    logic [BW-1:0] dir_data = '0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [BW-1:0] rand_block();
        logic [BW-1:0] b;
        for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return a & ~AW'(BW / 8 - 1);
    endfunction

    function automatic logic [BW-1:0] get_block(input logic [AW-1:0] a);
        if (!mem.exists(a)) mem[a] = rand_block();
        return mem[a];
    endfunction

    // Per-cycle compare, drive, and handshake bookkeeping, all at the falling edge.
    initial begin : cycle_proc
        logic [4:0] hs;
        req_v_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_data_i = '0;
        resp_ready_and_i = 1'b0; dma_pkt_yumi_i = 1'b0; dma_data_yumi_i = 1'b0;
        dma_data_i = '0; dma_data_v_i = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            hs = {req_ready_and_o, dma_pkt_v_o, dma_data_v_o, dma_data_ready_and_o, resp_v_o};
            if (!reset_n_i) begin
                check("reset_handshakes", BW'(hs), BW'(0));
                txn_open = 0; exp_pkt_next = 0; exp_resp_next = 0;
                pkt_hold = 0; data_hold = 0; resp_hold = 0;
                req_v_i = dir_pending;
                dma_pkt_yumi_i = 1'b0; dma_data_yumi_i = 1'b0; resp_ready_and_i = 1'b0;
                dma_data_v_i = 1'($urandom);
            end else begin
                check("onehot_handshake", BW'($countones(hs)), BW'(1));
                check("ready_when_idle", BW'(req_ready_and_o), BW'(!txn_open));
                if (exp_pkt_next)  check("pkt_latency", BW'(dma_pkt_v_o), BW'(1));
                if (exp_resp_next) check("resp_latency", BW'(resp_v_o), BW'(1));
                if (pkt_hold)  check("pkt_stall_hold", BW'(dma_pkt_v_o), BW'(1));
                if (data_hold) check("data_stall_hold", BW'(dma_data_v_o), BW'(1));
                if (resp_hold) check("resp_stall_hold", BW'(resp_v_o), BW'(1));
                if (dma_pkt_v_o) check("dma_pkt", BW'(dma_pkt_o), BW'({cur_write, cur_addr}));
                if (dma_data_v_o) begin
                    check("write_beat_kind", BW'(cur_write), BW'(1));
                    check("write_beat", BW'(dma_data_o), BW'(cur_data[wbeat*FW +: FW]));
                end
                if (dma_data_ready_and_o) check("read_beat_kind", BW'(cur_write), BW'(0));
                if (resp_v_o) begin
                    check("resp_write", BW'(resp_write_o), BW'(cur_write));
                    check("resp_addr", BW'(resp_addr_o), BW'(cur_addr));
                    check("resp_data", resp_data_o, cur_data);
                end

                // requester
                if (dir_pending) begin
                    req_v_i = 1'b1; req_write_i = dir_write;
                    req_addr_i = dir_addr; req_data_i = dir_data;
                end else begin
                    req_v_i = rand_req && (($urandom % 100) < p_req);
                    req_write_i = force_write ? 1'b1 : 1'($urandom);
                    req_addr_i = (($urandom % 4) == 0) ? AW'($urandom) : AW'($urandom_range(0, 255));
                    req_data_i = rand_block();
                end

                // DMA memory side
                if (bp_mode) begin
                    tog = ~tog;
                    dma_pkt_yumi_i  = dma_pkt_v_o && (pkt_wait >= 5);
                    pkt_wait        = dma_pkt_v_o ? (dma_pkt_yumi_i ? 0 : pkt_wait + 1) : 0;
                    dma_data_yumi_i = dma_data_v_o && tog;
                end else begin
                    dma_pkt_yumi_i  = dma_pkt_v_o ? (($urandom % 100) < p_pkt)
                                                  : (spur_yumi && (($urandom % 8) == 0));
                    dma_data_yumi_i = dma_data_v_o ? (($urandom % 100) < p_data)
                                                   : (spur_yumi && (($urandom % 8) == 0));
                end
                if (dma_data_ready_and_o) begin
                    dma_data_v_i = bp_mode ? tog : (($urandom % 100) < p_data);
                    dma_data_i   = cur_data[rbeat*FW +: FW];
                end else begin
                    dma_data_v_i = ($urandom % 100) < p_vin;
                    dma_data_i   = {$urandom, $urandom};
                end
                resp_ready_and_i = ($urandom % 100) < p_resp;

                // handshakes that the coming rising edge will perform
                exp_pkt_next = 0; exp_resp_next = 0;
                pkt_hold  = dma_pkt_v_o && !dma_pkt_yumi_i;
                data_hold = dma_data_v_o && !dma_data_yumi_i;
                resp_hold = resp_v_o && !resp_ready_and_i;
                if (req_v_i && req_ready_and_o) begin
                    txn_open = 1; cur_write = req_write_i; cur_addr = align(req_addr_i);
                    cur_data = req_write_i ? req_data_i : get_block(align(req_addr_i));
                    wbeat = 0; rbeat = 0; exp_pkt_next = 1; dir_pending = 0;
                    gaps.push_back(cyc - last_acc); last_acc = cyc;
                end
                if (dma_data_v_o && dma_data_yumi_i) begin
                    wbeat++;
                    if (wbeat == NF) exp_resp_next = 1;
                end
                if (dma_data_ready_and_o && dma_data_v_i) begin
                    rbeat++;
                    if (rbeat == NF) exp_resp_next = 1;
                end
                if (resp_v_o && resp_ready_and_i) begin
                    txn_open = 0;
                    if (cur_write) mem[cur_addr] = cur_data;
                end
            end
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk); #1;
            if (!txn_open && !dir_pending) return;
        end
        check("idle_timeout", BW'(0), BW'(1));
    endtask

    task automatic wait_resp();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); #1;
            if (resp_v_o) return;
        end
        check("resp_timeout", BW'(0), BW'(1));
    endtask

    task automatic set_knobs(input int unsigned pq, input int unsigned pp, input int unsigned pd,
                             input int unsigned pr, input int unsigned pv);
        p_req = pq; p_pkt = pp; p_data = pd; p_resp = pr; p_vin = pv;
    endtask

    initial begin : sequencer
        logic [BW-1:0] blk;
        logic [FW-1:0] beats[$];
        reset_n_i = 1'b0;
        #1;
        check("reset_state", BW'({req_ready_and_o, dma_pkt_v_o, dma_data_v_o,
                                  dma_data_ready_and_o, resp_v_o}), BW'(0));

        // Directed read pending across reset release: accepted on the first edge.
        for (int i = 0; i < NF; i++) blk[i*FW +: FW] = FW'(17 * (i + 1));
        mem[28'h0001040] = blk;
        dir_write = 1'b0; dir_addr = 28'h0001047; dir_data = rand_block(); dir_pending = 1;
        repeat (3) @(posedge clk);
        #2 reset_n_i = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        check("first_accept_pkt_v", BW'(dma_pkt_v_o), BW'(1));
        check("read_pkt_literal", BW'(dma_pkt_o), BW'(29'h0001040));
        wait_resp();
        check("read_resp_addr_literal", BW'(resp_addr_o), BW'(28'h0001040));
        check("read_resp_write_literal", BW'(resp_write_o), BW'(0));
        for (int i = 0; i < NF; i++)
            check("read_slice_literal", BW'(resp_data_o[i*FW +: FW]), BW'(17 * (i + 1)));
        wait_idle();

        // Directed write: slice i = i, beats must come out in order.
        for (int i = 0; i < NF; i++) blk[i*FW +: FW] = FW'(i);
        dir_write = 1'b1; dir_addr = 28'h200; dir_data = blk; dir_pending = 1;
        for (int k = 0; k < 300 && !resp_v_o; k++) begin
            @(negedge clk); #1;
            if (dma_pkt_v_o) check("write_pkt_literal", BW'(dma_pkt_o), BW'(29'h10000200));
            if (dma_data_v_o && dma_data_yumi_i) beats.push_back(dma_data_o);
        end
        check("write_beat_count", BW'(beats.size()), BW'(NF));
        for (int i = 0; i < beats.size(); i++)
            check("write_beat_literal", BW'(beats[i]), BW'(i));
        check("write_resp_literal", BW'({resp_v_o, resp_write_o}), BW'(2'b11));
        wait_idle();

        // Back-pressure pattern on a write and a read.
        bp_mode = 1;
        dir_write = 1'b1; dir_addr = 28'h0000480; dir_data = rand_block(); dir_pending = 1;
        wait_idle();
        dir_write = 1'b0; dir_addr = 28'h0000480; dir_pending = 1;
        wait_idle();
        bp_mode = 0;

        // Randomised traffic at several stall densities.
        spur_yumi = 1; rand_req = 1;
        set_knobs(100, 100, 100, 100, 30); repeat (600) @(negedge clk);
        set_knobs(60, 50, 50, 50, 50);     repeat (800) @(negedge clk);
        set_knobs(30, 20, 30, 20, 80);     repeat (800) @(negedge clk);
        rand_req = 0; spur_yumi = 0;
        set_knobs(0, 100, 100, 100, 0);
        wait_idle();

        // Zero-stall back-to-back writes.
        force_write = 1; set_knobs(100, 100, 100, 100, 0);
        gaps.delete(); rand_req = 1;
        repeat (60) @(negedge clk);
        #1 rand_req = 0;
        wait_idle();
        force_write = 0;
        check("b2b_accepts", BW'(gaps.size() >= 5), BW'(1));
        for (int i = 1; i < gaps.size(); i++) check("b2b_gap", BW'(gaps[i]), BW'(11));

        // Reset after three read beats, then a fresh read.
        dir_write = 1'b0; dir_addr = 28'h0000a13; dir_pending = 1;
        for (int k = 0; k < 100 && rbeat < 3; k++) begin @(negedge clk); #1; end
        check("reached_three_beats", BW'(rbeat), BW'(3));
        @(posedge clk);
        #2;
        check("pre_reset_busy", BW'(dma_data_ready_and_o), BW'(1));
        reset_n_i = 1'b0;
        #1;
        check("async_reset_outputs", BW'({req_ready_and_o, dma_pkt_v_o, dma_data_v_o,
                                          dma_data_ready_and_o, resp_v_o}), BW'(0));
        dir_write = 1'b0; dir_addr = 28'h0003f40; dir_pending = 1;
        repeat (2) @(posedge clk);
        #2 reset_n_i = 1'b1;
        wait_resp();
        check("post_reset_resp_addr", BW'(resp_addr_o), BW'(28'h0003f40));
        wait_idle();

        // Spurious read valids and consume strobes while idle.
        p_vin = 100; spur_yumi = 1;
        repeat (12) @(negedge clk);
        #1;
        check("idle_after_spurious", BW'(req_ready_and_o), BW'(1));
        p_vin = 0; spur_yumi = 0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, wanted completion");
        $fatal(1, "watchdog expired");
    end

endmodule
